// File: rtl/alu_bist_sequencer.sv
// ALU built-in self-test sequencer.
// Sweeps all eleven ALU operations over LFSR-generated operands, folds every
// ALU result into a 32-bit MISR and compares the final signature with a
// golden value supplied as a parameter.
// Optional build macro: ALU_BIST_ERR_INJECT_EN adds the err_inject input,
// which flips io_out[0] ahead of compaction to prove the checker can fail.
// The ALU_SEL_* codes normally come from ba201rv32i_consts.vh; the guarded
// defaults below let the block stand alone when that header is absent.

`ifndef ALU_SEL_WIDTH
`define ALU_SEL_WIDTH 4
`endif
`ifndef ALU_SEL_ADD
`define ALU_SEL_ADD   4'd0
`endif
`ifndef ALU_SEL_SUB
`define ALU_SEL_SUB   4'd1
`endif
`ifndef ALU_SEL_SLT
`define ALU_SEL_SLT   4'd2
`endif
`ifndef ALU_SEL_SLTU
`define ALU_SEL_SLTU  4'd3
`endif
`ifndef ALU_SEL_XOR
`define ALU_SEL_XOR   4'd4
`endif
`ifndef ALU_SEL_OR
`define ALU_SEL_OR    4'd5
`endif
`ifndef ALU_SEL_AND
`define ALU_SEL_AND   4'd6
`endif
`ifndef ALU_SEL_COPYB
`define ALU_SEL_COPYB 4'd7
`endif
`ifndef ALU_SEL_SLL
`define ALU_SEL_SLL   4'd8
`endif
`ifndef ALU_SEL_SRL
`define ALU_SEL_SRL   4'd9
`endif
`ifndef ALU_SEL_SRA
`define ALU_SEL_SRA   4'd10
`endif

module alu_bist_sequencer #(
  parameter int unsigned NUM_VECTORS  = 64,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2025,
  parameter logic [31:0] MISR_SEED    = 32'hFFFF_FFFF,
  parameter logic [31:0] EXPECTED_SIG = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [31:0]               signature,
  output logic [`ALU_SEL_WIDTH-1:0] io_sel,
  output logic [31:0]               io_in_a,
  output logic [31:0]               io_in_b,
  input  logic [31:0]               io_out
`ifdef ALU_BIST_ERR_INJECT_EN
  ,
  input  logic                      err_inject
`endif
);

  localparam int SW = `ALU_SEL_WIDTH;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] LFSR_INIT = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [11:0] LAST_VEC  = 12'(NUM_VECTORS - 1);
  localparam logic [3:0]  LAST_OP   = 4'd10;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [31:0] misr;
  logic [3:0]  op_idx;
  logic [11:0] vec_cnt;

  logic [31:0] capture_data;
  logic [31:0] lfsr_nxt;
  logic [31:0] misr_nxt;
  logic [3:0]  op_nxt;
  logic        last_vec;
  logic        last_op;

  // Operation sweep order: ADD, SUB, SLT, SLTU, XOR, OR, AND, COPYB, SLL, SRL, SRA.
  function automatic logic [SW-1:0] op_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return `ALU_SEL_ADD;
      4'd1:    return `ALU_SEL_SUB;
      4'd2:    return `ALU_SEL_SLT;
      4'd3:    return `ALU_SEL_SLTU;
      4'd4:    return `ALU_SEL_XOR;
      4'd5:    return `ALU_SEL_OR;
      4'd6:    return `ALU_SEL_AND;
      4'd7:    return `ALU_SEL_COPYB;
      4'd8:    return `ALU_SEL_SLL;
      4'd9:    return `ALU_SEL_SRL;
      4'd10:   return `ALU_SEL_SRA;
      default: return `ALU_SEL_ADD;
    endcase
  endfunction

  // Shift ops only look at a 5-bit shamt, so the upper operand bits are cleared.
  function automatic logic [31:0] operand_b(input logic [31:0] l, input logic [SW-1:0] sel);
    logic [31:0] b;
    b = {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A;
    if (sel == `ALU_SEL_SLL || sel == `ALU_SEL_SRL || sel == `ALU_SEL_SRA) begin
      b[31:5] = 27'd0;
    end
    return b;
  endfunction

  // One Galois step, right-shifting.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
  endfunction

  // CRC-32 style left-shifting MISR with the sampled data folded in.
  function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d);
    return ({m[30:0], 1'b0} ^ (m[31] ? MISR_POLY : 32'h0)) ^ d;
  endfunction

  // Next-vector values shared by the state update and the registered operand outputs.
  always_comb begin
`ifdef ALU_BIST_ERR_INJECT_EN
    capture_data = io_out ^ {31'd0, err_inject};
`else
    capture_data = io_out;
`endif
    last_vec = (vec_cnt == LAST_VEC);
    last_op  = (op_idx == LAST_OP);
    lfsr_nxt = lfsr_step(lfsr);
    misr_nxt = misr_step(misr, capture_data);
    op_nxt   = last_vec ? (op_idx + 4'd1) : op_idx;
  end

  // Sequencer FSM with registered status and ALU-drive outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= 32'h0;
      misr      <= 32'h0;
      op_idx    <= 4'd0;
      vec_cnt   <= 12'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 32'h0;
      io_sel    <= '0;
      io_in_a   <= 32'h0;
      io_in_b   <= 32'h0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= 32'h0;
          end
        end
        S_LOAD: begin
          lfsr      <= LFSR_INIT;
          misr      <= MISR_SEED;
          op_idx    <= 4'd0;
          vec_cnt   <= 12'd0;
          done      <= 1'b0;
          pass      <= 1'b0;
          signature <= 32'h0;
          io_sel    <= op_code(4'd0);
          io_in_a   <= LFSR_INIT;
          io_in_b   <= operand_b(LFSR_INIT, op_code(4'd0));
          state     <= S_APPLY;
        end
        S_APPLY: begin
          // Operands stay put so the combinational ALU result settles for capture.
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          misr    <= misr_nxt;
          lfsr    <= lfsr_nxt;
          vec_cnt <= last_vec ? 12'd0 : (vec_cnt + 12'd1);
          op_idx  <= op_nxt;
          if (last_op && last_vec) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            signature <= misr_nxt;
            pass      <= (misr_nxt == EXPECTED_SIG);
            io_sel    <= '0;
            io_in_a   <= 32'h0;
            io_in_b   <= 32'h0;
          end else begin
            state   <= S_APPLY;
            io_sel  <= op_code(op_nxt);
            io_in_a <= lfsr_nxt;
            io_in_b <= operand_b(lfsr_nxt, op_code(op_nxt));
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Testbench for alu_bist_sequencer: reference ALU with a switchable SRA fault,
// table of full runs plus hand-written reset, abort and held-start sequences.
// Build with ALU_BIST_ERR_INJECT_EN defined to include the injection run.

`timescale 1ns/1ps

`ifndef ALU_SEL_WIDTH
`define ALU_SEL_WIDTH 4
`endif
`ifndef ALU_SEL_ADD
`define ALU_SEL_ADD   4'd0
`endif
`ifndef ALU_SEL_SUB
`define ALU_SEL_SUB   4'd1
`endif
`ifndef ALU_SEL_SLT
`define ALU_SEL_SLT   4'd2
`endif
`ifndef ALU_SEL_SLTU
`define ALU_SEL_SLTU  4'd3
`endif
`ifndef ALU_SEL_XOR
`define ALU_SEL_XOR   4'd4
`endif
`ifndef ALU_SEL_OR
`define ALU_SEL_OR    4'd5
`endif
`ifndef ALU_SEL_AND
`define ALU_SEL_AND   4'd6
`endif
`ifndef ALU_SEL_COPYB
`define ALU_SEL_COPYB 4'd7
`endif
`ifndef ALU_SEL_SLL
`define ALU_SEL_SLL   4'd8
`endif
`ifndef ALU_SEL_SRL
`define ALU_SEL_SRL   4'd9
`endif
`ifndef ALU_SEL_SRA
`define ALU_SEL_SRA   4'd10
`endif

module tb_alu_bist_sequencer;

  localparam int          SW       = `ALU_SEL_WIDTH;
  localparam int          NV       = 4;
  localparam logic [31:0] SEED     = 32'hACE1_2025;
  localparam logic [31:0] MSEED    = 32'hFFFF_FFFF;
  localparam int          RUN_LEN  = 1 + 22 * NV;
  localparam int          MAX_WAIT = 2000;

  // Reference ALU; the faulty variant turns SRA into a logical shift.
  function automatic logic [31:0] ref_alu(input logic [SW-1:0] sel, input logic [31:0] a,
                                          input logic [31:0] b, input bit bad);
    case (sel)
      `ALU_SEL_ADD:   return a + b;
      `ALU_SEL_SUB:   return a - b;
      `ALU_SEL_SLT:   return {31'd0, ($signed(a) < $signed(b))};
      `ALU_SEL_SLTU:  return {31'd0, (a < b)};
      `ALU_SEL_XOR:   return a ^ b;
      `ALU_SEL_OR:    return a | b;
      `ALU_SEL_AND:   return a & b;
      `ALU_SEL_COPYB: return b;
      `ALU_SEL_SLL:   return a << b[4:0];
      `ALU_SEL_SRL:   return a >> b[4:0];
      `ALU_SEL_SRA:   return bad ? (a >> b[4:0]) : $unsigned($signed(a) >>> b[4:0]);
      default:        return 32'h0;
    endcase
  endfunction

  function automatic logic [SW-1:0] tb_op(input int i);
    case (i)
      0:       return `ALU_SEL_ADD;
      1:       return `ALU_SEL_SUB;
      2:       return `ALU_SEL_SLT;
      3:       return `ALU_SEL_SLTU;
      4:       return `ALU_SEL_XOR;
      5:       return `ALU_SEL_OR;
      6:       return `ALU_SEL_AND;
      7:       return `ALU_SEL_COPYB;
      8:       return `ALU_SEL_SLL;
      9:       return `ALU_SEL_SRL;
      default: return `ALU_SEL_SRA;
    endcase
  endfunction

  // Expected signature of one complete run.
  function automatic logic [31:0] model_sig(input bit bad, input bit inj);
    logic [31:0] l, m, a, b, r;
    l = (SEED == 32'h0) ? 32'h1 : SEED;
    m = MSEED;
    for (int op = 0; op < 11; op++) begin
      for (int v = 0; v < NV; v++) begin
        a = l;
        b = {l[15:0], l[31:16]} ^ 32'h5A5A_5A5A;
        if (op >= 8) b = b & 32'h0000_001F;
        r = ref_alu(tb_op(op), a, b, bad);
        if (inj && op == 0 && v == 0) r = r ^ 32'h1;
        m = ({m[30:0], 1'b0} ^ (m[31] ? 32'h04C1_1DB7 : 32'h0)) ^ r;
        l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
      end
    end
    return m;
  endfunction

  localparam logic [31:0] GOLDEN = model_sig(1'b0, 1'b0);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [31:0]   signature;
  logic [SW-1:0] io_sel;
  logic [31:0]   io_in_a;
  logic [31:0]   io_in_b;
  logic [31:0]   io_out;
  bit            faulty;
`ifdef ALU_BIST_ERR_INJECT_EN
  logic          err_inject;
`endif

  int checks = 0;
  int errors = 0;

  alu_bist_sequencer #(
    .NUM_VECTORS (NV),
    .LFSR_SEED   (SEED),
    .MISR_SEED   (MSEED),
    .EXPECTED_SIG(GOLDEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .io_sel    (io_sel),
    .io_in_a   (io_in_a),
    .io_in_b   (io_in_b),
    .io_out    (io_out)
`ifdef ALU_BIST_ERR_INJECT_EN
    ,
    .err_inject(err_inject)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb io_out = ref_alu(io_sel, io_in_a, io_in_b, faulty);

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit shift_sel(input logic [SW-1:0] s);
    return (s == `ALU_SEL_SLL) || (s == `ALU_SEL_SRL) || (s == `ALU_SEL_SRA);
  endfunction

  // Pulse start, then count busy cycles until done; optional injection on vector 0 CAPTURE.
  task automatic run_start(input bit inject, output int cycles, output bit shamt_ok);
    cycles   = 0;
    shamt_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && cycles < MAX_WAIT) begin
      cycles++;
`ifdef ALU_BIST_ERR_INJECT_EN
      err_inject = inject && (cycles == 3);
`else
      if (inject) $display("note: injection requested but err_inject not built");
`endif
      if (shift_sel(io_sel) && io_in_b[31:5] != 27'd0) shamt_ok = 1'b0;
      @(negedge clk);
    end
`ifdef ALU_BIST_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
  endtask

  typedef struct {
    string name;
    bit    bad;
    bit    inject;
    bit    exp_pass;
  } rec_t;

`ifdef ALU_BIST_ERR_INJECT_EN
  localparam int NREC = 5;
`else
  localparam int NREC = 3;
`endif

  rec_t recs [NREC];

  initial begin
    int          cyc;
    bit          sok;
    logic [31:0] exp_sig;

    recs[0] = '{name: "golden",      bad: 1'b0, inject: 1'b0, exp_pass: 1'b1};
    recs[1] = '{name: "faulty_sra",  bad: 1'b1, inject: 1'b0, exp_pass: 1'b0};
    recs[2] = '{name: "golden_again", bad: 1'b0, inject: 1'b0, exp_pass: 1'b1};
`ifdef ALU_BIST_ERR_INJECT_EN
    recs[3] = '{name: "inject",      bad: 1'b0, inject: 1'b1, exp_pass: 1'b0};
    recs[4] = '{name: "no_inject",   bad: 1'b0, inject: 1'b0, exp_pass: 1'b1};
    err_inject = 1'b0;
`endif

    start  = 1'b0;
    faulty = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-cycle during a run: everything clears without waiting for a clock.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check1("pre_reset_busy", busy, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_pass", pass, 1'b0);
    check32("rst_signature", signature, 32'h0);
    check32("rst_io_sel", 32'(io_sel), 32'h0);
    check32("rst_io_in_a", io_in_a, 32'h0);
    check32("rst_io_in_b", io_in_b, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check1("idle_busy", busy, 1'b0);
    check1("idle_done", done, 1'b0);

    // Full runs from the table.
    for (int i = 0; i < NREC; i++) begin
      faulty  = recs[i].bad;
      exp_sig = model_sig(recs[i].bad, recs[i].inject);
      run_start(recs[i].inject, cyc, sok);
      check_int({recs[i].name, "_busy_cycles"}, cyc, RUN_LEN);
      check1({recs[i].name, "_done"}, done, 1'b1);
      check1({recs[i].name, "_pass"}, pass, recs[i].exp_pass);
      check32({recs[i].name, "_signature"}, signature, exp_sig);
      check1({recs[i].name, "_shamt_zero"}, sok, 1'b1);
      if (!recs[i].exp_pass) check1({recs[i].name, "_sig_differs"}, signature != GOLDEN, 1'b1);
      faulty = 1'b0;
    end

    // Abort at busy cycle 30, then a fresh run must reproduce the golden signature.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check1("abort_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("abort_busy", busy, 1'b0);
    check32("abort_signature", signature, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_start(1'b0, cyc, sok);
    check_int("restart_busy_cycles", cyc, RUN_LEN);
    check1("restart_pass", pass, 1'b1);
    check32("restart_signature", signature, GOLDEN);

    // start held high throughout the run is not treated as a restart.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < MAX_WAIT) begin
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check_int("held_busy_cycles", cyc, RUN_LEN);
    check1("held_done", done, 1'b1);
    check32("held_signature", signature, GOLDEN);
    @(negedge clk);
    check1("held_stays_done", done, 1'b1);
    check1("held_no_rerun", busy, 1'b0);
    run_start(1'b0, cyc, sok);
    check_int("second_busy_cycles", cyc, RUN_LEN);
    check32("second_signature", signature, GOLDEN);
    check1("second_pass", pass, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
